adder_tree_pipe: RTL and testbench

- Parametrised, pipelined signed adder tree that sums N_IN two's-complement operands of width W into one full-precision result.
- Each tree level is a two-cycle split-carry adder: the low LSB_W bits are added in the first cycle and the high part in the second, using the registered carry.
- Adds valid/ready flow control, asynchronous reset and an optional accumulator.
- Sits in the datapath after the sample-capture logic and feeds downstream filtering and averaging.

---
 rtl/adder_tree_pkg.sv | 47 ++++
 rtl/adder_tree_node.sv | 59 +++++
 rtl/adder_tree_pipe.sv | 123 ++++++++++++
 tb/tb_adder_tree_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants and width helpers for the pipelined signed adder tree.
// The tree is laid out level by level on one flat bus; the offset helpers locate each level.
package adder_tree_pkg;

    localparam int LSB_W_DEF = 7;
    localparam int ACC_W_DEF = 20;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int sum_w(input int w, input int n_in);
        return w + clog2(n_in);
    endfunction

    function automatic int lvl_w(input int w, input int lvl);
        return w + lvl;
    endfunction

    // Bit offset of the operand group feeding level lvl on the flat data bus.
    function automatic int data_off(input int n_in, input int w, input int lvl);
        int o;
        o = 0;
        for (int k = 0; k < lvl; k++) begin
            o = o + (n_in >> k) * lvl_w(w, k);
        end
        return o;
    endfunction

    function automatic int vld_off(input int n_in, input int lvl);
        int o;
        o = 0;
        for (int k = 0; k < lvl; k++) begin
            o = o + (n_in >> k);
        end
        return o;
    endfunction

endpackage

// File: rtl/adder_tree_node.sv
// Two-stage split-carry adder of two signed operands: low slice first, high slice
// with the registered carry one cycle later. Result is one bit wider than the operands.
module adder_tree_node
    import adder_tree_pkg::*;
#(
    parameter int OP_W  = 12,
    parameter int LSB_W = LSB_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   valid_in,
    input  logic signed [OP_W-1:0] a,
    input  logic signed [OP_W-1:0] b,
    output logic                   valid_out,
    output logic signed [OP_W:0]   sum
);

    localparam int HI_W = OP_W - LSB_W;

    logic [LSB_W:0]   lo_r;
    logic [HI_W-1:0]  a_hi_r;
    logic [HI_W-1:0]  b_hi_r;
    logic             v_lo_r;
    logic [HI_W:0]    hi_s;

    // First stage: low-slice add with carry-out, high operand bits carried alongside
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_r   <= '0;
            a_hi_r <= '0;
            b_hi_r <= '0;
            v_lo_r <= 1'b0;
        end else if (en) begin
            lo_r   <= {1'b0, a[LSB_W-1:0]} + {1'b0, b[LSB_W-1:0]};
            a_hi_r <= a[OP_W-1:LSB_W];
            b_hi_r <= b[OP_W-1:LSB_W];
            v_lo_r <= valid_in;
        end
    end

    // High slice: sign-extended operands plus the registered low-slice carry
    always_comb begin
        hi_s = {a_hi_r[HI_W-1], a_hi_r} + {b_hi_r[HI_W-1], b_hi_r}
             + {{HI_W{1'b0}}, lo_r[LSB_W]};
    end

    // Second stage: assemble the full-width sum from the high result and delayed low bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            valid_out <= 1'b0;
        end else if (en) begin
            sum       <= {hi_s, lo_r[LSB_W-1:0]};
            valid_out <= v_lo_r;
        end
    end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree with valid/ready flow control and a global stall enable.
// Optional output accumulator enabled by defining ADDER_TREE_ACC_EN.
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int W     = 12,
    parameter int LSB_W = LSB_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_IN*W-1:0]               in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
`ifdef ADDER_TREE_ACC_EN
    input  logic                            acc_clr,
    output logic signed [ACC_W-1:0]         out_sum
`else
    output logic signed [sum_w(W,N_IN)-1:0] out_sum
`endif
);

    localparam int L     = clog2(N_IN);
    localparam int SUM_W = sum_w(W, N_IN);
    localparam int D_TOT = data_off(N_IN, W, L) + SUM_W;
    localparam int V_TOT = vld_off(N_IN, L) + 1;

    if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0 || LSB_W < 1 || LSB_W >= W || ACC_W < SUM_W) begin : g_bad_cfg
        $error("adder_tree_pipe: unsupported N_IN/W/LSB_W/ACC_W combination");
    end

    logic [D_TOT-1:0]        tree_s;
    logic [V_TOT-1:0]        vld_s;
    logic                    en_s;
    logic                    accept_s;
    logic signed [SUM_W-1:0] tree_sum_s;
    logic                    tree_valid_s;

    // Whole pipeline advances unless a finished result is waiting on the consumer
    always_comb begin
        en_s     = out_ready | ~out_valid;
        accept_s = in_valid & en_s;
    end

    assign in_ready          = en_s;
    assign tree_s[N_IN*W-1:0] = in_data;
    assign vld_s[N_IN-1:0]   = {N_IN{accept_s}};

    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int OW = lvl_w(W, l);
        localparam int NN = N_IN >> (l + 1);
        localparam int DI = data_off(N_IN, W, l);
        localparam int DO = data_off(N_IN, W, l + 1);
        localparam int VI = vld_off(N_IN, l);
        localparam int VO = vld_off(N_IN, l + 1);
        for (genvar j = 0; j < NN; j++) begin : g_node
            adder_tree_node #(
                .OP_W  (OW),
                .LSB_W (LSB_W)
            ) u_node (
                .clk       (clk),
                .rst       (rst),
                .en        (en_s),
                .valid_in  (vld_s[VI+2*j] & vld_s[VI+2*j+1]),
                .a         (tree_s[DI+(2*j)*OW +: OW]),
                .b         (tree_s[DI+(2*j+1)*OW +: OW]),
                .valid_out (vld_s[VO+j]),
                .sum       (tree_s[DO+j*(OW+1) +: OW+1])
            );
        end
    end

    assign tree_sum_s   = tree_s[D_TOT-1 -: SUM_W];
    assign tree_valid_s = vld_s[V_TOT-1];

`ifdef ADDER_TREE_ACC_EN
    logic [2*L-1:0]          clr_pipe_r;
    logic signed [ACC_W-1:0] acc_r;
    logic                    acc_v_r;
    logic signed [ACC_W-1:0] tree_ext_s;

    // Clear flag rides alongside its vector so it meets the tree sum at the accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_pipe_r <= '0;
        end else if (en_s) begin
            clr_pipe_r <= {clr_pipe_r[2*L-2:0], acc_clr};
        end
    end

    // Sign-extend the tree sum to accumulator width
    always_comb begin
        tree_ext_s = ACC_W'(tree_sum_s);
    end

    // Accumulator stage; wraps modulo 2^ACC_W and only moves on a valid vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= '0;
            acc_v_r <= 1'b0;
        end else if (en_s) begin
            acc_v_r <= tree_valid_s;
            if (tree_valid_s) begin
                if (clr_pipe_r[2*L-1]) begin
                    acc_r <= tree_ext_s;
                end else begin
                    acc_r <= acc_r + tree_ext_s;
                end
            end
        end
    end

    assign out_sum   = acc_r;
    assign out_valid = acc_v_r;
`else
    assign out_sum   = tree_sum_s;
    assign out_valid = tree_valid_s;
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: directed vectors, an arithmetic model with
// a scoreboard queue, per-cycle handshake/stall checks and literal expectations.
module tb_adder_tree_pipe;

    localparam int N_IN  = 8;
    localparam int W     = 12;
    localparam int LSB_W = 7;
`ifdef ADDER_TREE_ACC_EN
    localparam int ACC_W = 16;
    localparam int OUT_W = 16;
    localparam int LAT   = 7;
    localparam bit ACC_MODE = 1'b1;
`else
    localparam int ACC_W = 20;
    localparam int OUT_W = 15;
    localparam int LAT   = 6;
    localparam bit ACC_MODE = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [N_IN*W-1:0]       in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic                    acc_clr = 1'b0;
    logic signed [OUT_W-1:0] out_sum;

    int checks = 0;
    int errors = 0;

    longint exp_q[$];
    int     stamp_q[$];
    bit     haslit_q[$];
    longint lit_q[$];
    logic signed [ACC_W-1:0] acc_m = '0;
    int     en_edges = 0;
    bit     cur_has_lit = 1'b0;
    longint cur_lit = 0;
    bit     prev_stall = 1'b0;
    logic signed [OUT_W-1:0] prev_sum = '0;
    int     rdy_mode = 0;
    int     pat = 0;

    always #5 clk = ~clk;

    adder_tree_pipe #(
        .N_IN  (N_IN),
        .W     (W),
        .LSB_W (LSB_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ADDER_TREE_ACC_EN
        .acc_clr   (acc_clr),
`endif
        .out_sum   (out_sum)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int vsum(input logic [N_IN*W-1:0] v);
        int s;
        s = 0;
        for (int i = 0; i < N_IN; i++) s += int'($signed(v[i*W +: W]));
        return s;
    endfunction

    // operand i = (even ? a : b) + i*inc, plus extra on operand 0
    function automatic logic [N_IN*W-1:0] mk(input int a, input int b, input int inc, input int extra);
        logic [N_IN*W-1:0] v;
        int x;
        v = '0;
        for (int i = 0; i < N_IN; i++) begin
            x = ((i % 2 == 0) ? a : b) + i * inc + ((i == 0) ? extra : 0);
            v[i*W +: W] = W'(x);
        end
        return v;
    endfunction

    // Output pacing: always ready, or the repeating 1,0,0 pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready = (pat == 0);
                pat = (pat + 1) % 3;
            end
        end
    end

    // Monitor: handshake, stall stability, scoreboard compare, latency in enabled edges
    initial begin
        int s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("in_ready", in_ready, out_ready || !out_valid);
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_sum", out_sum, prev_sum);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", out_valid, 0);
                    end else begin
                        check("sum_vs_model", out_sum, exp_q[0]);
                        if (haslit_q[0]) check("sum_vs_literal", out_sum, lit_q[0]);
                        if (!prev_stall) check("latency", en_edges - stamp_q[0], LAT);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            void'(stamp_q.pop_front());
                            void'(haslit_q.pop_front());
                            void'(lit_q.pop_front());
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    s = vsum(in_data);
                    acc_m = (ACC_MODE && acc_clr) ? ACC_W'(s) : acc_m + ACC_W'(s);
                    exp_q.push_back(ACC_MODE ? longint'(acc_m) : longint'(s));
                    stamp_q.push_back(en_edges);
                    haslit_q.push_back(cur_has_lit);
                    lit_q.push_back(cur_lit);
                end
                prev_stall = out_valid && !out_ready;
                prev_sum = out_sum;
                if (in_ready) en_edges++;
            end
        end
    end

    task automatic send(input logic [N_IN*W-1:0] v, input bit clr, input bit has, input longint lit);
        bit ok;
        ok = 1'b0;
        in_data = v;
        acc_clr = clr;
        cur_has_lit = has;
        cur_lit = lit;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accepted", ok, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit stall_lit;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sum", out_sum, 0);
        check("reset_in_ready", in_ready, 1);

        check("pin_ramp", vsum(mk(0, 0, 1, 0)), 28);
        check("pin_min", vsum(mk(-2048, -2048, 0, 0)), -16384);
        check("pin_alt", vsum(mk(127, -128, 0, 0)), -4);
        @(posedge clk);
        #1;

`ifdef ADDER_TREE_ACC_EN
        send(mk(0, 0, 1, 0), 1'b1, 1'b1, 28);
        send(mk(0, 0, 1, 0), 1'b0, 1'b1, 56);
        send(mk(0, 0, 1, 0), 1'b0, 1'b1, 84);
        send(mk(0, 0, 1, 0), 1'b0, 1'b1, 112);
        send(mk(0, 0, 0, -5), 1'b1, 1'b1, -5);
        send(mk(2047, 2047, 0, 0), 1'b1, 1'b1, 16376);
        send(mk(2047, 2047, 0, 0), 1'b0, 1'b1, 32752);
        send(mk(2047, 2047, 0, 0), 1'b0, 1'b1, -16408);
        stall_lit = 1'b0;
`else
        send(mk(0, 0, 1, 0), 1'b0, 1'b1, 28);
        send(mk(-2048, -2048, 0, 0), 1'b0, 1'b1, -16384);
        send(mk(2047, 2047, 0, 0), 1'b0, 1'b1, 16376);
        send(mk(127, 127, 0, 0), 1'b0, 1'b1, 1016);
        send(mk(127, -128, 0, 0), 1'b0, 1'b1, -4);
        stall_lit = 1'b1;
`endif
        drain();

        rdy_mode = 1;
        for (int k = 0; k < 10; k++) send(mk(k, k, 1, 0), 1'b0, stall_lit, 8 * k + 28);
        drain();
        rdy_mode = 0;

        for (int k = 0; k < 3; k++) send(mk(1, 1, 0, 0), 1'b0, 1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum", out_sum, 0);
        exp_q.delete();
        stamp_q.delete();
        haslit_q.delete();
        lit_q.delete();
        acc_m = '0;
        prev_stall = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send(mk(0, 0, 1, 0), 1'b0, 1'b1, 28);
        drain();
        repeat (10) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
